mhpm_counter_bank: RTL and testbench
====================================

// Module: mhpm_counter_bank
// PURPOSE
// - Parametrised bank of RISC-V machine hardware performance monitor counters: mhpmcounter3..N, mhpmcounterh, mhpmevent, and mcountinhibit.
// - Generalises the fixed NUM_MHPM/NUM_EVENTS setup with four additions: counter width, saturate/wrap mode, sticky overflow flags, and an overflow interrupt.
// - Sits beside the machine CSR file; the CSR read/write path forwards the HPM address range here, and the pipeline drives the event vector.
// PARAMETERS
// - NUM_CNT     4             number of counters, mhpmcounter3..3+NUM_CNT-1; legal range 1..29
// - NUM_EVT     24            event lines; selector value 0 means "none"
// - CNT_W       64            counter width, 33..64; bits >= CNT_W read 0
// - SATURATE    0             1 = hold at all-ones on overflow; 0 = wrap to 0
// - INH_RO      0             1 = mcountinhibit is read-only, constant INH_BITS
// - INH_BITS    32'h0         mcountinhibit reset/constant value
// PORTS
// - clk_in          in   1        core clock
// - reset_n_in      in   1        async active-low reset
// - events_in       in   NUM_EVT  per-cycle event pulses; bit 0 is ignored
// - csr_wr_in       in   1        CSR write strobe
// - csr_wr_addr_in  in   12       CSR write address
// - csr_wdata_in    in   32       CSR write data
// - csr_rd_in       in   1        CSR read strobe
// - csr_rd_addr_in  in   12       CSR read address
// - csr_rdata_out   out  32       read data, registered
// - csr_rvalid_out  out  1        asserted 1 cycle after csr_rd_in
// - csr_rhit_out    out  1        read address was in this bank's range (valid with rvalid)
// - ovf_out         out  NUM_CNT  sticky overflow flags (OF bits)
// - ovf_irq_out     out  1        |(OF & OFIE), registered
// BEHAVIOUR
// - Reset: counters 0, event regs 0, mcountinhibit = INH_BITS, all outputs 0.
// - Address map:
//   - mhpmcounter(3+i) = 0xB03+i, low 32 bits
//   - mhpmcounterh(3+i) = 0xB83+i, bits CNT_W-1:32
//   - mhpmevent(3+i) = 0x323+i
//   - mcountinhibit = 0x320, bit 3+i inhibits counter i
// - Addresses 0xB03..0xB1F, 0xB83..0xB9F and 0x323..0x33F with index >= NUM_CNT: hit=1, read 0, writes ignored.
// - mhpmevent layout:
//   - [EV_SEL_SZ-1:0] = selector
//   - [30] = OFIE, overflow interrupt enable
//   - [31] = OF, sticky
//   - all other bits read 0
//   - selector writes >= NUM_EVT are stored as 0
// - Increment: counter i += 1 at clk edge when sel!=0 && events_in[sel] && !inhibit[3+i]. One increment per cycle max.
// - Overflow, when the counter is all-ones (CNT_W bits) and increments:
//   - SATURATE=0: wraps to 0, OF<=1.
//   - SATURATE=1: holds at all-ones, OF<=1.
//   - In both modes, OF is set on the same edge as the wrap/hold.
// - OF is cleared only by a CSR write to mhpmevent with wdata[31]=0. Writing 1 sets it, for software test.
// - Simultaneous CSR write and increment on the same counter: the write wins and that cycle's increment is dropped. Applies to the lo and hi halves independently: writing lo still allows a carry into hi? No: any write to either half of counter i blocks the whole increment.
// - Simultaneous overflow and mhpmevent write with wdata[31]=0: the write wins and OF=0.
// - mcountinhibit:
//   - Writes affect bits [3+NUM_CNT-1:3] only; other bits read 0.
//   - INH_RO=1: writes are ignored.
//   - Takes effect on the next cycle's events.
// - Read: csr_rd_in samples the address; rdata/rvalid/rhit appear next cycle. The value returned is pre-write when a read and write hit the same register in one cycle.
// - Out of range: rhit=0, rdata=0, and writes are ignored.
// - ovf_irq_out: registered OR, so 1-cycle latency after OF/OFIE change.
// - Reset mid-operation: asynchronous clear to reset values; a pending read returns nothing (rvalid=0).
// STRUCTURE
// - Shared package (cpu_params_pkg / csr addr pkg) holds:
//   - CSR_MHPMCNT_BASE, CSR_MHPMCNTH_BASE, CSR_MHPMEVT_BASE, CSR_MCNTINH constants
//   - the event-register typedef (sel, ofie, of)
//   - EV_SEL_SZ
// - Sub-module hpm_counter: one counter, its event register, and its increment/write/overflow logic. The bank generates NUM_CNT instances plus address decode, the read mux and the inhibit register.
// TESTING
// - Reset, then read 0xB03, 0x323, 0x320 -> all return 0 with rhit=1.
// - Set mhpmevent3=5, pulse events_in[5] for 10 cycles -> read 0xB03 returns 10. Inhibit bit 3 set -> count frozen.
// - Write lo=0xFFFF_FFFF, hi=0xFFFF_FFFF with OFIE=1, then one event:
//   - SATURATE=0 -> count 0, ovf_out[0]=1, ovf_irq_out=1 next cycle.
//   - SATURATE=1 -> count stays all-ones.
// - Event pulse and CSR write to 0xB03 (0x1234) in the same cycle -> read returns 0x1234. Write mhpmevent with bit31=0 -> OF clears and irq drops.
// - NUM_CNT=4: access 0xB08 -> rhit=1, rdata 0. Access 0xBA0 -> rhit=0. Write selector 30 with NUM_EVT=24 -> reads back 0.
// - Assert reset_n_in low mid-count and mid-read -> counters 0, rvalid=0 on the following edge.

Source files
------------

// File: rtl/mhpm_counter_bank_pkg.sv
// mhpm_counter_bank_pkg
// Shared definitions for the machine hardware performance monitor bank:
//   - CSR base addresses for mhpmcounter, mhpmcounterh, mhpmevent, mcountinhibit
//   - the event-register layout (selector, overflow-interrupt enable, sticky overflow)
//   - an address decoder and an event-register-to-CSR-word helper
// No ports (package).
package mhpm_counter_bank_pkg;

  localparam logic [11:0] CSR_MHPMCNT_BASE  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCNTH_BASE = 12'hB83;
  localparam logic [11:0] CSR_MHPMEVT_BASE  = 12'h323;
  localparam logic [11:0] CSR_MCNTINH       = 12'h320;

  // Architectural slots 3..31 give 29 addresses per CSR group.
  localparam logic [11:0] HPM_LAST_OFS = 12'd28;

  localparam int EV_SEL_SZ = 5;

  typedef struct packed {
    logic                 of;
    logic                 ofie;
    logic [EV_SEL_SZ-1:0] sel;
  } evt_reg_t;

  typedef enum logic [2:0] {
    CSR_NONE,
    CSR_CNT,
    CSR_CNTH,
    CSR_EVT,
    CSR_INH
  } csr_kind_e;

  typedef struct packed {
    csr_kind_e  kind;
    logic [4:0] idx;
  } csr_dec_t;

  // Classifies an address into a CSR group and a slot index (0 = counter 3).
  // Slots beyond the implemented counters still decode, so they hit but read 0.
  function automatic csr_dec_t decodeAddr(input logic [11:0] addr);
    csr_dec_t d;
    d.kind = CSR_NONE;
    d.idx  = '0;
    if (addr >= CSR_MHPMCNT_BASE && addr <= CSR_MHPMCNT_BASE + HPM_LAST_OFS) begin
      d.kind = CSR_CNT;
      d.idx  = 5'(addr - CSR_MHPMCNT_BASE);
    end else if (addr >= CSR_MHPMCNTH_BASE && addr <= CSR_MHPMCNTH_BASE + HPM_LAST_OFS) begin
      d.kind = CSR_CNTH;
      d.idx  = 5'(addr - CSR_MHPMCNTH_BASE);
    end else if (addr >= CSR_MHPMEVT_BASE && addr <= CSR_MHPMEVT_BASE + HPM_LAST_OFS) begin
      d.kind = CSR_EVT;
      d.idx  = 5'(addr - CSR_MHPMEVT_BASE);
    end else if (addr == CSR_MCNTINH) begin
      d.kind = CSR_INH;
    end
    return d;
  endfunction

  function automatic logic [31:0] evtToWord(input evt_reg_t e);
    logic [31:0] w;
    w                = '0;
    w[31]            = e.of;
    w[30]            = e.ofie;
    w[EV_SEL_SZ-1:0] = e.sel;
    return w;
  endfunction

endpackage

// File: rtl/mhpm_counter_bank_hpm_counter.sv
// hpm_counter
// One performance counter with its event register. Handles event selection,
// increment, CSR writes to either counter half or the event register, and
// overflow (wrap or saturate) with a sticky OF flag.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   events_i        per-cycle event pulses (bit 0 never counts)
//   inhibit_i       mcountinhibit bit for this counter
//   wr_lo_i/wr_hi_i CSR write to counter bits 31:0 / CNT_W-1:32
//   wr_evt_i        CSR write to the event register
//   wdata_i         CSR write data
//   cnt_o           counter value zero-extended to 64 bits
//   evt_o           current event register
module hpm_counter
  import mhpm_counter_bank_pkg::*;
#(
  parameter int NUM_EVT  = 24,
  parameter int CNT_W    = 64,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_EVT-1:0] events_i,
  input  logic               inhibit_i,
  input  logic               wr_lo_i,
  input  logic               wr_hi_i,
  input  logic               wr_evt_i,
  input  logic [31:0]        wdata_i,
  output logic [63:0]        cnt_o,
  output evt_reg_t           evt_o
);

  localparam logic [EV_SEL_SZ:0] NumEvtW = (EV_SEL_SZ + 1)'(NUM_EVT);
  localparam logic [CNT_W-1:0]   CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  evt_reg_t                    evt_q, evt_d;
  logic [(1<<EV_SEL_SZ)-1:0]   evPad;
  logic [EV_SEL_SZ-1:0]        selIn;
  logic                        incEn;
  logic                        ofSet;

  // Widen the event vector to the full selector range so any stored selector
  // indexes a defined bit.
  always_comb begin
    evPad                = '0;
    evPad[NUM_EVT-1:0]   = events_i;
  end

  assign incEn = (evt_q.sel != '0) && evPad[evt_q.sel] && !inhibit_i;
  assign selIn = wdata_i[EV_SEL_SZ-1:0];

  // A write to either half suppresses that cycle's increment entirely,
  // including any carry or overflow.
  always_comb begin
    cnt_d = cnt_q;
    ofSet = 1'b0;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end else if (incEn) begin
      if (&cnt_q) begin
        ofSet = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // Event-register writes take priority over a simultaneous overflow so
  // software clearing OF never loses the race.
  always_comb begin
    evt_d = evt_q;
    if (ofSet) begin
      evt_d.of = 1'b1;
    end
    if (wr_evt_i) begin
      evt_d.sel  = ({1'b0, selIn} >= NumEvtW) ? '0 : selIn;
      evt_d.ofie = wdata_i[30];
      evt_d.of   = wdata_i[31];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  always_comb begin
    cnt_o              = '0;
    cnt_o[CNT_W-1:0]   = cnt_q;
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/mhpm_counter_bank.sv
// mhpm_counter_bank
// Bank of RISC-V mhpmcounter3.. counters with event selectors, mcountinhibit,
// sticky overflow flags and an overflow interrupt.
// Ports:
//   clk_in, reset_n_in          clock, async active-low reset
//   events_in[NUM_EVT]          per-cycle event pulses from the pipeline
//   csr_wr_in/_addr/_wdata      CSR write port
//   csr_rd_in/_addr             CSR read request
//   csr_rdata_out/_rvalid/_rhit registered read response, one cycle later
//   ovf_out[NUM_CNT]            sticky OF bits
//   ovf_irq_out                 registered OR of OF & OFIE
module mhpm_counter_bank
  import mhpm_counter_bank_pkg::*;
#(
  parameter int          NUM_CNT  = 4,
  parameter int          NUM_EVT  = 24,
  parameter int          CNT_W    = 64,
  parameter bit          SATURATE = 1'b0,
  parameter bit          INH_RO   = 1'b0,
  parameter logic [31:0] INH_BITS = 32'h0
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic [NUM_EVT-1:0] events_in,
  input  logic               csr_wr_in,
  input  logic [11:0]        csr_wr_addr_in,
  input  logic [31:0]        csr_wdata_in,
  input  logic               csr_rd_in,
  input  logic [11:0]        csr_rd_addr_in,
  output logic [31:0]        csr_rdata_out,
  output logic               csr_rvalid_out,
  output logic               csr_rhit_out,
  output logic [NUM_CNT-1:0] ovf_out,
  output logic               ovf_irq_out
);

  localparam logic [NUM_CNT-1:0] InhRst = INH_BITS[3 +: NUM_CNT];

  csr_dec_t           wrDec, rdDec;
  logic [NUM_CNT-1:0] inh_q;
  logic [63:0]        cntAll [NUM_CNT];
  evt_reg_t           evtAll [NUM_CNT];
  logic [NUM_CNT-1:0] ofVec, ofieVec;
  logic [31:0]        rdata_d, rdata_q;
  logic               rhit_d, rhit_q;
  logic               rvalid_q;
  logic               irq_q;

  assign wrDec = decodeAddr(csr_wr_addr_in);
  assign rdDec = decodeAddr(csr_rd_addr_in);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic slotHit;
    assign slotHit = csr_wr_in && (wrDec.idx == 5'(i));

    hpm_counter #(
      .NUM_EVT  (NUM_EVT),
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk_i     (clk_in),
      .rst_ni    (reset_n_in),
      .events_i  (events_in),
      .inhibit_i (inh_q[i]),
      .wr_lo_i   (slotHit && (wrDec.kind == CSR_CNT)),
      .wr_hi_i   (slotHit && (wrDec.kind == CSR_CNTH)),
      .wr_evt_i  (slotHit && (wrDec.kind == CSR_EVT)),
      .wdata_i   (csr_wdata_in),
      .cnt_o     (cntAll[i]),
      .evt_o     (evtAll[i])
    );

    assign ofVec[i]   = evtAll[i].of;
    assign ofieVec[i] = evtAll[i].ofie;
  end

  // Inhibit bits live at CSR bits 3.. so bit i here gates counter 3+i.
  // With INH_RO the register just holds its reset constant.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      inh_q <= InhRst;
    end else if (!INH_RO && csr_wr_in && (wrDec.kind == CSR_INH)) begin
      inh_q <= csr_wdata_in[3 +: NUM_CNT];
    end
  end

  // Read mux works on current register state, so a same-cycle write is not
  // visible to the read.
  always_comb begin
    rdata_d = '0;
    rhit_d  = (rdDec.kind != CSR_NONE);
    case (rdDec.kind)
      CSR_CNT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rdDec.idx == 5'(i)) rdata_d = cntAll[i][31:0];
        end
      end
      CSR_CNTH: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rdDec.idx == 5'(i)) rdata_d = cntAll[i][63:32];
        end
      end
      CSR_EVT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rdDec.idx == 5'(i)) rdata_d = evtToWord(evtAll[i]);
        end
      end
      CSR_INH: begin
        rdata_d[3 +: NUM_CNT] = inh_q;
      end
      default: begin
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rdata_q  <= '0;
      rhit_q   <= 1'b0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= csr_rd_in;
      rdata_q  <= csr_rd_in ? rdata_d : '0;
      rhit_q   <= csr_rd_in && rhit_d;
      irq_q    <= |(ofVec & ofieVec);
    end
  end

  assign csr_rdata_out  = rdata_q;
  assign csr_rvalid_out = rvalid_q;
  assign csr_rhit_out   = rhit_q;
  assign ovf_out        = ofVec;
  assign ovf_irq_out    = irq_q;

endmodule

// File: tb/tb_mhpm_counter_bank.sv
// tb_mhpm_counter_bank
// Self-checking bench for mhpm_counter_bank. Two instances share all inputs:
// one wrapping (SATURATE=0) and one saturating (SATURATE=1). Reads push
// expected responses into a scoreboard queue that a negedge monitor pops.
module tb_mhpm_counter_bank;

  localparam int NUM_CNT = 4;
  localparam int NUM_EVT = 24;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_EVT-1:0] events;
  logic               csrWr;
  logic [11:0]        csrWrAddr;
  logic [31:0]        csrWdata;
  logic               csrRd;
  logic [11:0]        csrRdAddr;

  logic [31:0]        rdataA, rdataB;
  logic               rvalidA, rvalidB, rhitA, rhitB;
  logic [NUM_CNT-1:0] ovfA, ovfB;
  logic               irqA, irqB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic [31:0] dataSat;
  } exp_t;

  typedef struct {
    string       name;
    bit          doWr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    bit          expHit;
  } vec_t;

  exp_t sbQ[$];
  exp_t monExp;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mhpm_counter_bank #(
    .NUM_CNT (NUM_CNT), .NUM_EVT (NUM_EVT), .CNT_W (64),
    .SATURATE (1'b0), .INH_RO (1'b0), .INH_BITS (32'h0)
  ) dut (
    .clk_in (clk), .reset_n_in (reset_n), .events_in (events),
    .csr_wr_in (csrWr), .csr_wr_addr_in (csrWrAddr), .csr_wdata_in (csrWdata),
    .csr_rd_in (csrRd), .csr_rd_addr_in (csrRdAddr),
    .csr_rdata_out (rdataA), .csr_rvalid_out (rvalidA), .csr_rhit_out (rhitA),
    .ovf_out (ovfA), .ovf_irq_out (irqA)
  );

  mhpm_counter_bank #(
    .NUM_CNT (NUM_CNT), .NUM_EVT (NUM_EVT), .CNT_W (64),
    .SATURATE (1'b1), .INH_RO (1'b0), .INH_BITS (32'h0)
  ) dutSat (
    .clk_in (clk), .reset_n_in (reset_n), .events_in (events),
    .csr_wr_in (csrWr), .csr_wr_addr_in (csrWrAddr), .csr_wdata_in (csrWdata),
    .csr_rd_in (csrRd), .csr_rd_addr_in (csrRdAddr),
    .csr_rdata_out (rdataB), .csr_rvalid_out (rvalidB), .csr_rhit_out (rhitB),
    .ovf_out (ovfB), .ovf_irq_out (irqB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    csrWr     = 1'b1;
    csrWrAddr = addr;
    csrWdata  = data;
    tick();
    csrWr     = 1'b0;
  endtask

  task automatic pushExp(input string name, input logic [31:0] data, input logic hit,
                         input logic [31:0] dataSat);
    exp_t e;
    e.name    = name;
    e.data    = data;
    e.hit     = hit;
    e.dataSat = dataSat;
    sbQ.push_back(e);
  endtask

  task automatic csrRead(input string name, input logic [11:0] addr, input logic [31:0] expData,
                         input logic expHit, input logic [31:0] expSat);
    csrRd     = 1'b1;
    csrRdAddr = addr;
    pushExp(name, expData, expHit, expSat);
    tick();
    csrRd     = 1'b0;
  endtask

  function automatic vec_t mkVec(input string name, input bit doWr, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input bit expHit);
    vec_t v;
    v.name    = name;
    v.doWr    = doWr;
    v.addr    = addr;
    v.wdata   = wdata;
    v.expData = expData;
    v.expHit  = expHit;
    return v;
  endfunction

  task automatic applyStimulus();
    foreach (vecs[k]) begin
      if (vecs[k].doWr) csrWrite(vecs[k].addr, vecs[k].wdata);
      csrRead(vecs[k].name, vecs[k].addr, vecs[k].expData, vecs[k].expHit, vecs[k].expData);
    end
  endtask

  // Scoreboard monitor: every read response pops one expectation.
  always @(negedge clk) begin
    if (rvalidA || rvalidB) begin
      checkOutput("rvalidPair", 32'(rvalidB), 32'(rvalidA));
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRvalid", 32'd1, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput({monExp.name, ".data"}, rdataA, monExp.data);
        checkOutput({monExp.name, ".hit"}, 32'(rhitA), 32'(monExp.hit));
        checkOutput({monExp.name, ".satData"}, rdataB, monExp.dataSat);
        checkOutput({monExp.name, ".satHit"}, 32'(rhitB), 32'(monExp.hit));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    events    = '0;
    csrWr     = 1'b0;
    csrWrAddr = '0;
    csrWdata  = '0;
    csrRd     = 1'b0;
    csrRdAddr = '0;

    vecs.push_back(mkVec("rstCnt3",   0, 12'hB03, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("rstEvt3",   0, 12'h323, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("rstInh",    0, 12'h320, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("rstCnth3",  0, 12'hB83, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("cnt8Ign",   1, 12'hB08, 32'hDEADBEEF, 32'h0,        1));
    vecs.push_back(mkVec("cnth9Ign",  1, 12'hB89, 32'h1,        32'h0,        1));
    vecs.push_back(mkVec("evt8Ign",   1, 12'h328, 32'h5,        32'h0,        1));
    vecs.push_back(mkVec("cntTop",    0, 12'hB1F, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("cnthTop",   0, 12'hB9F, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("evtTop",    1, 12'h33F, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mkVec("outB20",    0, 12'hB20, 32'h0,        32'h0,        0));
    vecs.push_back(mkVec("outBA0",    0, 12'hBA0, 32'h0,        32'h0,        0));
    vecs.push_back(mkVec("outB02",    0, 12'hB02, 32'h0,        32'h0,        0));
    vecs.push_back(mkVec("out322",    1, 12'h322, 32'hFFFF,     32'h0,        0));
    vecs.push_back(mkVec("selBig",    1, 12'h323, 32'h1E,       32'h0,        1));
    vecs.push_back(mkVec("selMax",    1, 12'h323, 32'h17,       32'h17,       1));
    vecs.push_back(mkVec("evtBits",   1, 12'h324, 32'hFFFFFFFF, 32'hC0000000, 1));
    vecs.push_back(mkVec("evtClr",    1, 12'h324, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("inhAll",    1, 12'h320, 32'hFFFFFFFF, 32'h78,       1));
    vecs.push_back(mkVec("inhClr",    1, 12'h320, 32'h0,        32'h0,        1));
    vecs.push_back(mkVec("cntLo1",    1, 12'hB04, 32'h12345678, 32'h12345678, 1));
    vecs.push_back(mkVec("cntHi1",    1, 12'hB84, 32'hABCDEF01, 32'hABCDEF01, 1));
    vecs.push_back(mkVec("cntLo1Keep",0, 12'hB04, 32'h0,        32'h12345678, 1));

    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checkOutput("rstRvalid", 32'(rvalidA), 32'd0);
    checkOutput("rstOvf",    32'({ovfA, ovfB}), 32'd0);
    checkOutput("rstIrq",    32'({irqA, irqB}), 32'd0);

    applyStimulus();

    // Ten event-5 pulses, then inhibit freezes the count.
    csrWrite(12'h323, 32'h5);
    events[5] = 1'b1;
    repeat (10) tick();
    events[5] = 1'b0;
    csrRead("count10", 12'hB03, 32'd10, 1'b1, 32'd10);
    csrWrite(12'h320, 32'h8);
    events[5] = 1'b1;
    repeat (5) tick();
    events[5] = 1'b0;
    csrRead("inhFrozen", 12'hB03, 32'd10, 1'b1, 32'd10);
    csrWrite(12'h320, 32'h0);

    // Overflow from all-ones with OFIE set.
    csrWrite(12'h323, 32'h40000005);
    csrWrite(12'hB03, 32'hFFFFFFFF);
    csrWrite(12'hB83, 32'hFFFFFFFF);
    events[5] = 1'b1;
    tick();
    events[5] = 1'b0;
    checkOutput("ovfSet",     32'(ovfA[0]), 32'd1);
    checkOutput("ovfSetSat",  32'(ovfB[0]), 32'd1);
    checkOutput("irqLag",     32'({irqA, irqB}), 32'd0);
    tick();
    checkOutput("irqUp",      32'({irqA, irqB}), 32'b11);
    csrRead("ovfLo", 12'hB03, 32'h0, 1'b1, 32'hFFFFFFFF);
    csrRead("ovfHi", 12'hB83, 32'h0, 1'b1, 32'hFFFFFFFF);
    csrRead("ovfEvt", 12'h323, 32'hC0000005, 1'b1, 32'hC0000005);

    // Counter write beats a same-cycle increment.
    events[5] = 1'b1;
    csrWrite(12'hB03, 32'h1234);
    events[5] = 1'b0;
    csrRead("wrWins", 12'hB03, 32'h1234, 1'b1, 32'h1234);
    checkOutput("noOvfOnWr", 32'(ovfB[0]), 32'd1);

    // Software clears OF; interrupt drops one cycle later.
    csrWrite(12'h323, 32'h40000005);
    checkOutput("ofClr",     32'({ovfA[0], ovfB[0]}), 32'd0);
    checkOutput("irqHold",   32'({irqA, irqB}), 32'b11);
    tick();
    checkOutput("irqDrop",   32'({irqA, irqB}), 32'd0);

    // Overflow coinciding with an event-register write leaves OF clear.
    csrWrite(12'hB03, 32'hFFFFFFFF);
    csrWrite(12'hB83, 32'hFFFFFFFF);
    events[5] = 1'b1;
    csrWrite(12'h323, 32'h40000005);
    events[5] = 1'b0;
    checkOutput("ofWrWins",  32'({ovfA[0], ovfB[0]}), 32'd0);
    csrRead("wrapLo", 12'hB03, 32'h0, 1'b1, 32'hFFFFFFFF);
    csrRead("wrapHi", 12'hB83, 32'h0, 1'b1, 32'hFFFFFFFF);

    // Read and write of the same register in one cycle returns the old value.
    csrWr     = 1'b1;
    csrWrAddr = 12'hB04;
    csrWdata  = 32'h55;
    csrRead("preWrite", 12'hB04, 32'h12345678, 1'b1, 32'h12345678);
    csrWr     = 1'b0;
    csrRead("postWrite", 12'hB04, 32'h55, 1'b1, 32'h55);

    // Reset while counting and with a read in flight.
    csrWrite(12'h323, 32'h5);
    events[5] = 1'b1;
    repeat (3) tick();
    csrRd     = 1'b1;
    csrRdAddr = 12'hB03;
    #2 reset_n = 1'b0;
    tick();
    checkOutput("midRstRvalid", 32'({rvalidA, rvalidB}), 32'd0);
    checkOutput("midRstOvf",    32'({ovfA, ovfB}), 32'd0);
    csrRd     = 1'b0;
    events    = '0;
    reset_n   = 1'b1;
    tick();
    csrRead("postRstCnt", 12'hB03, 32'h0, 1'b1, 32'h0);
    csrRead("postRstEvt", 12'h323, 32'h0, 1'b1, 32'h0);
    csrRead("postRstCnt4", 12'hB04, 32'h0, 1'b1, 32'h0);

    repeat (3) tick();
    checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
